// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory line port between the I-cache and
// the D-cache. One request is latched at a time, forwarded to memory and the
// response is routed back to the owner of the grant.
// Optional feature macro: CACHE_ARB_ROUND_ROBIN_EN (alternating grant on
// simultaneous requests instead of fixed D-cache priority).
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [LINE_W-1:0]   r_wdata_q;
  logic                r_we_q;

  logic                w_i_req;
  logic                w_d_req;
  logic                w_any_req;
  logic                w_grant_d;

  assign w_i_req   = i_read;
  assign w_d_req   = d_read | d_write;
  assign w_any_req = w_i_req | w_d_req;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // 0 = I-cache was served last, 1 = D-cache was served last
  logic r_last_q;

  // On a tie, the requester that was not served last wins
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_q);

  // Remember who received the most recent grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_q <= 1'b0;
    end else if (r_state == IDLE && w_any_req) begin
      r_last_q <= w_grant_d;
    end
  end
`else
  // Fixed priority: any D-cache request beats the I-cache
  assign w_grant_d = w_d_req;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: grant only from IDLE, release on the memory response
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_next = w_grant_d ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Capture the winning request; the copy is held for the whole access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_q  <= '0;
      r_wdata_q <= '0;
      r_we_q    <= 1'b0;
    end else if (r_state == IDLE && w_any_req) begin
      if (w_grant_d) begin
        r_addr_q <= d_address;
        r_we_q   <= d_write;     // a write dominates a simultaneous read
        if (d_write) begin
          r_wdata_q <= d_wdata;
        end
      end else begin
        r_addr_q <= i_address;
        r_we_q   <= 1'b0;
      end
    end
  end

  // Memory strobes are decoded from registered state only, so they cannot
  // glitch and drop as soon as the state is reset
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = r_addr_q;
    pmem_wdata   = r_wdata_q;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    if (r_state == SERVE_I || r_state == SERVE_D) begin
      pmem_read  = ~r_we_q;
      pmem_write = r_we_q;
    end
    i_resp = (r_state == SERVE_I) & pmem_resp;
    d_resp = (r_state == SERVE_D) & pmem_resp;
  end

  // Read data is a plain pass-through; it only matters while resp is high
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed bench for cache_arbiter with an expected-grant
// scoreboard. Build with CACHE_ARB_ROUND_ROBIN_EN defined to test the
// alternating-grant variant.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] i_rdata, d_rdata;
  logic          i_resp, d_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } txn_t;

  txn_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_d, input bit we, input logic [AW-1:0] addr,
                      input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
    txn_t t;
    t.is_d = is_d; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    sb.push_back(t);
  endtask

  // Wait for the next grant, check it against the scoreboard head, answer it
  // after 'lat' strobe cycles. rel: 0 keep requests, 1 drop served, 2 drop all.
  task automatic serve_one(input int lat, input int rel, input bit scramble, output int waited);
    txn_t e;
    waited = 0;
    @(negedge clk);
    while (!(pmem_read || pmem_write) && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    chk("grant_timeout", LW'(waited < 20), LW'(1));
    if (sb.size() == 0) begin
      chk("scoreboard_empty", LW'(0), LW'(1));
      return;
    end
    e = sb.pop_front();
    chk("pmem_write", LW'(pmem_write), LW'(e.we));
    chk("pmem_read", LW'(pmem_read), LW'(!e.we));
    chk("pmem_address", LW'(pmem_address), LW'(e.addr));
    if (e.we) chk("pmem_wdata", pmem_wdata, e.wdata);
    for (int i = 0; i < lat - 1; i++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        d_address = $urandom;
        i_address = $urandom;
        for (int j = 0; j < 8; j++) d_wdata[j*32 +: 32] = $urandom;
      end
      @(negedge clk);
      chk("hold_strobe", LW'({pmem_read, pmem_write}), LW'({!e.we, e.we}));
      chk("hold_address", LW'(pmem_address), LW'(e.addr));
      if (e.we) chk("hold_wdata", pmem_wdata, e.wdata);
      chk("early_resp", LW'({i_resp, d_resp}), LW'(0));
    end
    @(posedge clk);
    #1;
    pmem_resp  = 1'b1;
    pmem_rdata = e.rdata;
    @(negedge clk);
    chk("resp_route", LW'({i_resp, d_resp}), LW'({!e.is_d, e.is_d}));
    chk("resp_strobe", LW'({pmem_read, pmem_write}), LW'({!e.we, e.we}));
    if (e.is_d) chk("d_rdata", d_rdata, e.rdata);
    else        chk("i_rdata", i_rdata, e.rdata);
    @(posedge clk);
    #1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    if (rel == 2) begin
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end else if (rel == 1) begin
      if (e.is_d) begin d_read = 1'b0; d_write = 1'b0; end
      else i_read = 1'b0;
    end
    @(negedge clk);
    chk("dead_cycle", LW'({pmem_read, pmem_write, i_resp, d_resp}), LW'(0));
    $display("txn %s %s addr=%08h waited=%0d", e.is_d ? "D" : "I", e.we ? "WR" : "RD", e.addr, waited);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            w, w2;
    bit            last_d;
    bit            win_d;
    logic [LW-1:0] wd;
    logic [LW-1:0] a5;
    logic [LW-1:0] rd;

    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", LW'({pmem_read, pmem_write, i_resp, d_resp}), LW'(0));
    chk("reset_address", LW'(pmem_address), LW'(0));
    chk("reset_wdata", pmem_wdata, '0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single I read, memory answers after 5 strobe cycles
    a5 = {32{8'hA5}};
    i_read = 1'b1; i_address = 32'h0000_0100;
    push(1'b0, 1'b0, 32'h100, '0, a5);
    serve_one(5, 1, 1'b0, w);
    chk("i_latency", LW'(w), LW'(1));

    // D write with inputs disturbed mid-transaction
    tick();
    wd = {8{32'h1234_5678}};
    d_write = 1'b1; d_address = 32'h200; d_wdata = wd;
    push(1'b1, 1'b1, 32'h200, wd, {8{32'hDEAD_BEEF}});
    serve_one(4, 1, 1'b1, w);
    chk("d_latency", LW'(w), LW'(1));

    // Simultaneous I and D reads (last served so far: D)
    tick();
    i_read = 1'b1; i_address = 32'h100;
    d_read = 1'b1; d_address = 32'h300;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b0, 32'h100, '0, {8{32'h1111_1111}});
    push(1'b1, 1'b0, 32'h300, '0, {8{32'h3333_3333}});
`else
    push(1'b1, 1'b0, 32'h300, '0, {8{32'h3333_3333}});
    push(1'b0, 1'b0, 32'h100, '0, {8{32'h1111_1111}});
`endif
    serve_one(3, 1, 1'b0, w);
    serve_one(2, 1, 1'b0, w2);
    chk("one_dead_cycle", LW'(w2), LW'(0));

    // d_read and d_write together: write only
    tick();
    wd = {8{32'h0F0F_00FF}};
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h500; d_wdata = wd;
    push(1'b1, 1'b1, 32'h500, wd, '0);
    serve_one(2, 1, 1'b0, w);

    // Spurious memory response while idle
    tick();
    pmem_resp = 1'b1;
    pmem_rdata = {8{32'hBAD0_BAD0}};
    @(negedge clk);
    chk("spurious_resp", LW'({i_resp, d_resp}), LW'(0));
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("spurious_strobe", LW'({pmem_read, pmem_write}), LW'(0));

    // Reset during a D write: strobe drops without a clock edge
    tick();
    d_write = 1'b1; d_address = 32'h400; d_wdata = {8{32'h5555_AAAA}};
    w = 0;
    @(negedge clk);
    while (!pmem_write && w < 20) begin w++; @(negedge clk); end
    chk("rst_write_started", LW'(pmem_write), LW'(1));
    #1 rst = 1'b1;
    #1;
    chk("rst_async_strobe", LW'({pmem_read, pmem_write}), LW'(0));
    d_write = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_resp", LW'({pmem_read, pmem_write, i_resp, d_resp}), LW'(0));
    end

    // Both requests held for 4 transactions straight after reset
    tick();
    i_read = 1'b1; i_address = 32'h600;
    d_read = 1'b1; d_address = 32'h700;
    last_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      win_d = !last_d;
`else
      win_d = 1'b1;
`endif
      rd = {8{32'hC0DE_0000 + k}};
      push(win_d, 1'b0, win_d ? 32'h700 : 32'h600, '0, rd);
      last_d = win_d;
    end
    for (int k = 0; k < 4; k++) begin
      serve_one(2, (k == 3) ? 2 : 0, 1'b0, w);
      if (k > 0) chk("held_gap", LW'(w), LW'(0));
    end

    // Back in IDLE: a fresh I read gets minimum latency
    tick();
    i_read = 1'b1; i_address = 32'h800;
    push(1'b0, 1'b0, 32'h800, '0, {8{32'h8888_0001}});
    serve_one(1, 1, 1'b0, w);
    chk("final_latency", LW'(w), LW'(1));
    chk("scoreboard_drained", LW'(sb.size()), LW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
